pipeline_mem_arbiter: RTL and testbench

Arbitrates the single-port unified memory between the pipeline's instruction-fetch (IF) port and its data (MEM-stage) port. Sequences each access through a request/acknowledge handshake with the memory, returns read data with a one-cycle ready pulse, and produces the pipeline Stall signal. Handles IF flush on taken jumps, prevents fetch starvation, and aborts memory accesses that time out.

---
 rtl/pipeline_mem_arbiter.sv | 124 ++++++++++++
 tb/tb_pipeline_mem_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_mem_arbiter.sv
// Arbiter for the single-port unified memory. It serves the instruction-fetch port
// and the data port one access at a time, and produces the pipeline stall signal.
module pipeline_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_IF_WAIT = 3,
  parameter int TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ack,
  output logic              stall,
  output logic              err
);

  localparam int WAIT_W = (MAX_IF_WAIT > 0) ? $clog2(MAX_IF_WAIT + 1) : 1;
  localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_IF_WAIT);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              discard;
  logic              grant_mem;
  logic              grant_if;

  function automatic logic [WAIT_W-1:0] sat_inc_wait(input logic [WAIT_W-1:0] v);
    return (v >= WAIT_MAX) ? v : v + 1'b1;
  endfunction

  // Fetch overrides the data port only once it has watched MAX_IF_WAIT data grants go by.
  assign grant_mem = mem_req && !(if_req && (wait_cnt == WAIT_MAX) && !if_flush);
  assign grant_if  = if_req && !if_flush;

  // Held low during reset so that every output is quiet while the block is in reset.
  assign stall = reset && ((mem_req && !mem_ready) || (if_req && !if_ready && !if_flush));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      to_cnt    <= '0;
      discard   <= 1'b0;
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      if_rdata  <= '0;
      if_ready  <= 1'b0;
      mem_rdata <= '0;
      mem_ready <= 1'b0;
      err       <= 1'b0;
    end else begin
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      err       <= 1'b0;
      case (state)
        IDLE: begin
          discard <= 1'b0;
          if (grant_mem) begin
            state     <= BUSY_MEM;
            ram_req   <= 1'b1;
            ram_we    <= mem_we;
            ram_addr  <= mem_addr;
            ram_wdata <= mem_wdata;
            to_cnt    <= '0;
            if (if_req) wait_cnt <= sat_inc_wait(wait_cnt);
          end else if (grant_if) begin
            state     <= BUSY_IF;
            ram_req   <= 1'b1;
            ram_we    <= 1'b0;
            ram_addr  <= if_addr;
            ram_wdata <= '0;
            to_cnt    <= '0;
            wait_cnt  <= '0;
          end
        end
        BUSY_IF, BUSY_MEM: begin
          if (ram_ack) begin
            ram_req <= 1'b0;
            state   <= IDLE;
            if (state == BUSY_MEM) begin
              mem_ready <= 1'b1;
              if (!ram_we) mem_rdata <= ram_rdata;
            end else if (!discard && !if_flush) begin
              if_ready <= 1'b1;
              if_rdata <= ram_rdata;
            end
          end else if (to_cnt == TO_LAST) begin
            // Abort: the requester sees neither ready nor data and simply retries.
            ram_req <= 1'b0;
            err     <= 1'b1;
            state   <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
            if ((state == BUSY_IF) && if_flush) discard <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      if (if_flush) wait_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Bench for pipeline_mem_arbiter: a table of single transactions, hand-written corner
// sequences, and randomized dual-port traffic checked against a word-array memory model.
module tb_pipeline_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_flush, mem_req, mem_we, ram_ack;
  logic [31:0] if_addr, mem_addr, mem_wdata, ram_rdata;
  logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata;
  logic        if_ready, mem_ready, ram_req, ram_we, stall, err;

  int checks = 0;
  int failures = 0;

  logic [31:0] ram_mem [256];
  logic [31:0] ref_mem [256];
  int resp_lat = 0;
  bit resp_noack = 1'b0;
  bit resp_rand = 1'b0;
  int r_cnt = 0;

  always #5 clk = ~clk;

  pipeline_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_IF_WAIT(3), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack),
    .stall(stall), .err(err)
  );

  function automatic int idx(input logic [31:0] a);
    return int'(a[9:2]);
  endfunction

  function automatic logic [31:0] rnd_addr();
    logic [7:0] w;
    w = 8'($urandom_range(0, 255));
    return {22'd0, w, 2'b00};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, want);
    end
  endtask

  // Memory responder: acks after resp_lat cycles of ram_req, randomly, or never.
  initial begin
    ram_ack = 1'b0;
    ram_rdata = '0;
    forever begin
      @(negedge clk);
      if (!ram_req) begin
        ram_ack = 1'b0;
        r_cnt = 0;
      end else if (resp_noack) begin
        ram_ack = 1'b0;
      end else if (resp_rand ? ($urandom_range(0, 1) == 1) : (r_cnt >= resp_lat)) begin
        ram_ack = 1'b1;
        ram_rdata = ram_mem[idx(ram_addr)];
        if (ram_we) ram_mem[idx(ram_addr)] = ram_wdata;
      end else begin
        ram_ack = 1'b0;
        r_cnt++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          is_mem;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] want;
    int          cyc;
  } vec_t;

  vec_t vt[6];

  task automatic run_vec(input vec_t v, input int n);
    int  cyc;
    bit  got;
    @(negedge clk);
    resp_lat = v.lat;
    if (v.is_mem) begin
      mem_req = 1'b1; mem_we = v.we; mem_addr = v.addr; mem_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    cyc = 0;
    got = 1'b0;
    while (cyc < 50 && !got) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk($sformatf("v%0d_grant_req", n), 32'(ram_req), 1);
        chk($sformatf("v%0d_grant_addr", n), ram_addr, v.addr);
        chk($sformatf("v%0d_grant_we", n), 32'(ram_we), 32'(v.we));
        chk($sformatf("v%0d_stall_busy", n), 32'(stall), 1);
      end
      if (cyc == v.cyc - 1) begin
        chk($sformatf("v%0d_hold_addr", n), ram_addr, v.addr);
        chk($sformatf("v%0d_hold_we", n), 32'(ram_we), 32'(v.we));
        if (v.we) chk($sformatf("v%0d_hold_wdata", n), ram_wdata, v.wdata);
      end
      got = v.is_mem ? mem_ready : if_ready;
    end
    chk($sformatf("v%0d_ready_cycle", n), cyc, v.cyc);
    chk($sformatf("v%0d_rdata", n), v.is_mem ? mem_rdata : if_rdata, v.want);
    chk($sformatf("v%0d_stall_done", n), 32'(stall), 0);
    mem_req = 1'b0;
    if_req = 1'b0;
    if (v.is_mem && v.we) ref_mem[idx(v.addr)] = v.wdata;
    @(negedge clk);
    chk($sformatf("v%0d_ready_pulse", n), 32'(v.is_mem ? mem_ready : if_ready), 0);
    chk($sformatf("v%0d_rdata_held", n), v.is_mem ? mem_rdata : if_rdata, v.want);
  endtask

  initial begin
    int c, k, hi, run;
    bit seen_err, seen_rdy;
    bit mem_done, if_done;
    logic [31:0] grants[$];
    logic [31:0] g_want[5];
    logic [31:0] last_load;

    for (int i = 0; i < 256; i++) ram_mem[i] = 32'h1000_0000 + 32'(i);
    ram_mem[1]  = 32'h2008_0005;
    ram_mem[64] = 32'hDEAD_BEEF;
    for (int i = 0; i < 256; i++) ref_mem[i] = ram_mem[i];

    vt[0] = '{1'b0, 1'b0, 32'h0000_0004, 32'h0,          0, 32'h2008_0005, 2};
    vt[1] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,          0, 32'hDEAD_BEEF, 2};
    vt[2] = '{1'b1, 1'b1, 32'h0000_0008, 32'h1234_5678, 2, 32'hDEAD_BEEF, 4};
    vt[3] = '{1'b0, 1'b0, 32'h0000_0008, 32'h0,          1, 32'h1234_5678, 3};
    vt[4] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,          3, 32'h1234_5678, 5};
    vt[5] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,          0, 32'h1000_0010, 2};

    reset = 1'b0;
    if_req = 1'b1; if_addr = '0; if_flush = 1'b0;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ram_req", 32'(ram_req), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_readies", {30'd0, if_ready, mem_ready}, 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_stall", 32'(stall), 0);
    if_req = 1'b0;
    mem_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vt[i], i);

    // Contention: data port first, fetch on the edge right after mem_ready.
    @(negedge clk);
    resp_lat = 0;
    if_req = 1'b1; if_addr = 32'h4;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100;
    @(negedge clk);
    chk("cont_first_addr", ram_addr, 32'h100);
    @(negedge clk);
    chk("cont_mem_ready", 32'(mem_ready), 1);
    chk("cont_mem_rdata", mem_rdata, 32'hDEAD_BEEF);
    chk("cont_if_not_ready", 32'(if_ready), 0);
    mem_req = 1'b0;
    @(negedge clk);
    chk("cont_if_grant", 32'(ram_req), 1);
    chk("cont_if_addr", ram_addr, 32'h4);
    @(negedge clk);
    chk("cont_if_ready", 32'(if_ready), 1);
    chk("cont_if_rdata", if_rdata, 32'h2008_0005);
    if_req = 1'b0;

    // Starvation: three data grants, then fetch is forced, then data resumes.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h4;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100;
    k = 0; c = 0; hi = 0;
    while (c < 100 && (mem_req || if_req)) begin
      @(negedge clk);
      c++;
      if (ram_req && hi == 0) grants.push_back(ram_addr);
      hi = int'(ram_req);
      if (mem_ready) begin
        k++;
        if (k < 4) mem_addr = 32'h100 + 32'(4 * k);
        else mem_req = 1'b0;
      end
      if (if_ready) if_req = 1'b0;
    end
    g_want = '{32'h100, 32'h104, 32'h108, 32'h4, 32'h10C};
    chk("starve_grant_count", grants.size(), 5);
    for (int i = 0; i < 5 && i < grants.size(); i++)
      chk($sformatf("starve_grant%0d", i), grants[i], g_want[i]);

    // Flush while the fetch is in flight: result discarded, next PC served.
    @(negedge clk);
    resp_lat = 2;
    if_req = 1'b1; if_addr = 32'h8;
    @(negedge clk);
    chk("flush_grant_addr", ram_addr, 32'h8);
    if_flush = 1'b1;
    #1;
    chk("flush_stall", 32'(stall), 0);
    if_req = 1'b0;
    @(negedge clk);
    if_flush = 1'b0;
    if_req = 1'b1; if_addr = 32'h40;
    @(negedge clk);
    chk("flush_addr_held", ram_addr, 32'h8);
    chk("flush_ack_seen", 32'(ram_ack), 1);
    @(negedge clk);
    chk("flush_no_ready", 32'(if_ready), 0);
    chk("flush_rdata_kept", if_rdata, 32'h2008_0005);
    seen_rdy = 1'b0;
    c = 0;
    while (c < 30 && !seen_rdy) begin
      @(negedge clk);
      c++;
      seen_rdy = if_ready;
    end
    chk("flush_next_ready", 32'(seen_rdy), 1);
    chk("flush_next_rdata", if_rdata, 32'h1000_0010);
    if_req = 1'b0;

    // Timeout on a load that is never acknowledged, then a successful retry.
    @(negedge clk);
    resp_noack = 1'b1; resp_lat = 0;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100;
    hi = 0; seen_err = 1'b0; seen_rdy = 1'b0; c = 0;
    while (c < 400 && !seen_err) begin
      @(negedge clk);
      c++;
      if (ram_req) hi++;
      if (mem_ready) seen_rdy = 1'b1;
      if (err) seen_err = 1'b1;
    end
    chk("to_err_pulse", 32'(seen_err), 1);
    chk("to_req_cycles", hi, 255);
    chk("to_req_dropped", 32'(ram_req), 0);
    chk("to_no_ready", 32'(seen_rdy), 0);
    resp_noack = 1'b0;
    @(negedge clk);
    chk("to_err_one_cycle", 32'(err), 0);
    chk("to_retry_req", 32'(ram_req), 1);
    chk("to_retry_addr", ram_addr, 32'h100);
    @(negedge clk);
    chk("to_retry_ready", 32'(mem_ready), 1);
    chk("to_retry_rdata", mem_rdata, 32'hDEAD_BEEF);
    mem_req = 1'b0;

    // Asynchronous reset in the middle of a data access.
    @(negedge clk);
    resp_noack = 1'b1;
    mem_req = 1'b1; mem_addr = 32'h104; if_req = 1'b1; if_addr = 32'h4;
    repeat (3) @(negedge clk);
    chk("ar_busy", 32'(ram_req), 1);
    #2 reset = 1'b0;
    #1;
    chk("ar_ram_req", 32'(ram_req), 0);
    chk("ar_ram_addr", ram_addr, 0);
    chk("ar_stall", 32'(stall), 0);
    chk("ar_readies", {29'd0, if_ready, mem_ready, err}, 0);
    @(negedge clk);
    mem_req = 1'b0; if_req = 1'b0; resp_noack = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("ar_idle_after", 32'(ram_req), 0);
    mem_req = 1'b1; mem_addr = 32'h100;
    @(negedge clk);
    chk("ar_regrant", 32'(ram_req), 1);
    @(negedge clk);
    chk("ar_serve_ready", 32'(mem_ready), 1);
    chk("ar_serve_rdata", mem_rdata, 32'hDEAD_BEEF);
    mem_req = 1'b0;

    // Randomized concurrent traffic against the memory model.
    resp_rand = 1'b1;
    last_load = 32'hDEAD_BEEF;
    mem_done = 1'b0;
    if_done = 1'b0;
    fork
      begin
        for (int t = 0; t < 60; t++) begin
          bit done;
          int w;
          repeat ($urandom_range(0, 2)) @(negedge clk);
          mem_we = 1'($urandom_range(0, 1));
          mem_addr = rnd_addr();
          mem_wdata = $urandom;
          mem_req = 1'b1;
          done = 1'b0;
          w = 0;
          while (!done && w < 500) begin
            @(negedge clk);
            w++;
            done = mem_ready;
          end
          if (!done) chk("rnd_mem_timeout", 0, 1);
          else if (mem_we) begin
            chk("rnd_store_rdata_kept", mem_rdata, last_load);
            ref_mem[idx(mem_addr)] = mem_wdata;
          end else begin
            chk("rnd_load_rdata", mem_rdata, ref_mem[idx(mem_addr)]);
            last_load = ref_mem[idx(mem_addr)];
          end
          mem_req = 1'b0;
        end
        mem_done = 1'b1;
      end
      begin
        for (int t = 0; t < 60; t++) begin
          bit done;
          int w;
          repeat ($urandom_range(0, 2)) @(negedge clk);
          if_addr = rnd_addr();
          if_req = 1'b1;
          done = 1'b0;
          w = 0;
          while (!done && w < 500) begin
            @(negedge clk);
            w++;
            done = if_ready;
          end
          if (!done) chk("rnd_if_timeout", 0, 1);
          else chk("rnd_if_rdata", if_rdata, ref_mem[idx(if_addr)]);
          if_req = 1'b0;
        end
        if_done = 1'b1;
      end
      begin
        run = 0;
        for (int cy = 0; cy < 20000 && !(mem_done && if_done); cy++) begin
          @(posedge clk);
          #1;
          if (if_ready) run = 0;
          else if (mem_ready && if_req) begin
            run++;
            chk("rnd_if_starved", 32'(run <= 4), 1);
          end
        end
      end
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
